// File: rtl/monster_wave_scheduler.sv
// Level/wave monster spawner: paces spawns on frame ticks, tracks path leaks and lives.
// Latency: enable pulses 2 Clk after the gap expires; backpressure: stalls in ALLOC while every slot is used.
module monster_wave_scheduler #(
    parameter int NUM_SLOTS  = 8,
    parameter int GAP_FRAMES = 90,
    parameter int WAVE_PAUSE = 180,
    parameter int NUM_WAVES  = 3,
    parameter int LIVES      = 5
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_clk,
    input  logic                 start,
    input  logic [2:0]           level_index,
    input  logic [NUM_SLOTS-1:0] used_array,
    input  logic [NUM_SLOTS-1:0] achieve_array,
    output logic [NUM_SLOTS-1:0] enable,
    output logic [2:0]           Summon,
    output logic [1:0]           wave_index,
    output logic [3:0]           spawn_count,
    output logic [2:0]           lives,
    output logic                 busy,
    output logic                 level_clear,
    output logic                 game_over
);

    localparam int GW = 8;

    typedef enum logic [2:0] {
        IDLE, WAIT_GAP, ALLOC, SPAWN, WAIT_CLEAR, DONE, LOST
    } state_t;

    state_t               state_q, state_d;
    logic                 frame_clk_q, frame_clk_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [1:0]           wave_q, wave_d;
    logic [3:0]           count_q, count_d;
    logic [2:0]           lives_q, lives_d;
    logic [2:0]           level_q, level_d;
    logic [NUM_SLOTS-1:0] slot_q, slot_d;
    logic [NUM_SLOTS-1:0] leak_q, leak_d;

    logic [NUM_SLOTS-1:0] free, lowest_free, new_leak;
    logic [7:0]           leak_cnt;
    logic [3:0]           per_wave;
    logic [2:0]           spawn_type;
    logic                 active, clear_done;

    always_comb begin
        free        = ~used_array;
        lowest_free = free & (~free + NUM_SLOTS'(1));
        active      = (state_q == WAIT_GAP) || (state_q == ALLOC) ||
                      (state_q == SPAWN) || (state_q == WAIT_CLEAR);
        enable      = (state_q == SPAWN) ? slot_q : '0;

        if (level_q >= 3'd2)      per_wave = 4'd8;
        else if (level_q == 3'd1) per_wave = 4'd6;
        else                      per_wave = 4'd4;

        // Last monster of the third and later waves is the boss.
        if (wave_q == 2'd0)      spawn_type = 3'd0;
        else if (wave_q == 2'd1) spawn_type = count_q[0] ? 3'd2 : 3'd0;
        else                     spawn_type = (count_q == per_wave - 4'd1) ? 3'd6 : 3'd2;
        Summon = (state_q == SPAWN) ? spawn_type : 3'd0;

        new_leak = active ? (achieve_array & used_array & ~leak_q & ~enable) : '0;
        leak_cnt = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            leak_cnt = leak_cnt + 8'(new_leak[k]);
        end
        clear_done = &(free | leak_q);

        busy        = active;
        level_clear = (state_q == DONE);
        game_over   = (state_q == LOST);
        wave_index  = wave_q;
        spawn_count = count_q;
        lives       = lives_q;
    end

    always_comb begin
        state_d      = state_q;
        frame_clk_d  = frame_clk;
        frame_tick_d = frame_clk & ~frame_clk_q;
        gap_d        = gap_q;
        wave_d       = wave_q;
        count_d      = count_q;
        level_d      = level_q;
        slot_d       = slot_q;
        // A flag lives only while its slot is occupied by the same monster.
        leak_d       = (leak_q | new_leak) & used_array & ~enable;
        if (leak_cnt >= {5'd0, lives_q}) lives_d = 3'd0;
        else                             lives_d = lives_q - leak_cnt[2:0];

        if (active && (lives_q == 3'd0)) begin
            state_d = LOST;
        end else begin
            case (state_q)
                IDLE, DONE, LOST: begin
                    if (start) begin
                        level_d = level_index;
                        lives_d = 3'(LIVES);
                        wave_d  = 2'd0;
                        count_d = 4'd0;
                        gap_d   = GW'(WAVE_PAUSE);
                        leak_d  = '0;
                        state_d = WAIT_GAP;
                    end
                end
                WAIT_GAP: begin
                    if (gap_q == '0)       state_d = ALLOC;
                    else if (frame_tick_q) gap_d   = gap_q - GW'(1);
                end
                ALLOC: begin
                    if (count_q == per_wave) begin
                        state_d = WAIT_CLEAR;
                    end else if (|free) begin
                        slot_d  = lowest_free;
                        state_d = SPAWN;
                    end
                end
                SPAWN: begin
                    count_d = count_q + 4'd1;
                    gap_d   = GW'(GAP_FRAMES);
                    state_d = WAIT_GAP;
                end
                WAIT_CLEAR: begin
                    if (clear_done) begin
                        if (wave_q == 2'(NUM_WAVES - 1)) begin
                            state_d = DONE;
                        end else begin
                            wave_d  = wave_q + 2'd1;
                            count_d = 4'd0;
                            gap_d   = GW'(WAVE_PAUSE);
                            state_d = WAIT_GAP;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            frame_clk_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            gap_q        <= '0;
            wave_q       <= 2'd0;
            count_q      <= 4'd0;
            lives_q      <= 3'(LIVES);
            level_q      <= 3'd0;
            slot_q       <= '0;
            leak_q       <= '0;
        end else begin
            state_q      <= state_d;
            frame_clk_q  <= frame_clk_d;
            frame_tick_q <= frame_tick_d;
            gap_q        <= gap_d;
            wave_q       <= wave_d;
            count_q      <= count_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            slot_q       <= slot_d;
            leak_q       <= leak_d;
        end
    end

endmodule

// File: tb/tb_monster_wave_scheduler.sv
// Directed + randomized bench for monster_wave_scheduler with a slot-occupancy reference model.
module tb_monster_wave_scheduler;

    logic       Clk = 1'b0;
    logic       Reset_n, frame_clk, start;
    logic [2:0] level_index;
    logic [7:0] used_array, achieve_array;
    logic [7:0] enable;
    logic [2:0] Summon;
    logic [1:0] wave_index;
    logic [3:0] spawn_count;
    logic [2:0] lives;
    logic       busy, level_clear, game_over;

    always #5 Clk = ~Clk;

    monster_wave_scheduler #(
        .NUM_SLOTS(8), .GAP_FRAMES(2), .WAVE_PAUSE(3), .NUM_WAVES(3), .LIVES(2)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
        .level_index(level_index), .used_array(used_array), .achieve_array(achieve_array),
        .enable(enable), .Summon(Summon), .wave_index(wave_index), .spawn_count(spawn_count),
        .lives(lives), .busy(busy), .level_clear(level_clear), .game_over(game_over)
    );

    typedef struct {
        logic [7:0] en;
        logic [2:0] sm;
        int         fr;
    } spawn_t;

    spawn_t q[$];
    int checks = 0;
    int errors = 0;
    int frames = 0;

    always @(negedge Clk) begin
        if (enable != 8'h00) q.push_back('{en: enable, sm: Summon, fr: frames});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        frames++;
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        repeat (7) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_type(input int w, input int n, input int pw);
        if (w == 0) return 0;
        if (w == 1) return (n % 2 == 1) ? 2 : 0;
        return (n == pw - 1) ? 6 : 2;
    endfunction

    function automatic int lowest_free(input logic [7:0] u);
        for (int k = 0; k < 8; k++) if (!u[k]) return k;
        return -1;
    endfunction

    task automatic wait_spawn(input int max_fr, output spawn_t s);
        int i = 0;
        while (q.size() == 0 && i < max_fr) begin
            frame();
            i++;
        end
        if (q.size() == 0) begin
            chk("spawn_timeout", q.size(), 1);
            s = '{en: 8'h00, sm: 3'd0, fr: -1};
        end else begin
            s = q.pop_front();
        end
    endtask

    task automatic run_spawns(input int w, input int pw, input int n0);
        for (int n = n0; n < pw; n++) begin
            spawn_t s;
            int idx;
            int exp_slot;
            idx = $urandom_range(7, 0);
            if (used_array == 8'hFF || $urandom_range(1, 0) == 1) used_array[idx[2:0]] = 1'b0;
            exp_slot = lowest_free(used_array);
            wait_spawn(6, s);
            chk("spawn_slot", s.en, 32'(1) << exp_slot);
            chk("summon_type", s.sm, ref_type(w, n, pw));
            chk("spawn_count", spawn_count, n + 1);
            used_array = used_array | s.en;
        end
    endtask

    task automatic clear_wave(input int w, input int pw);
        repeat (3) frame();
        for (int guard = 0; guard < 16 && used_array != 8'h00; guard++) begin
            int k;
            k = $urandom_range(7, 0);
            while (!used_array[k[2:0]]) k = (k + 1) % 8;
            used_array[k[2:0]] = 1'b0;
            step();
        end
        step();
        step();
        if (w == 2) begin
            chk("level_clear", level_clear, 1);
            chk("busy_done", busy, 0);
            chk("hold_wave", wave_index, 2);
            chk("hold_count", spawn_count, pw);
        end else begin
            chk("wave_adv", wave_index, w + 1);
            chk("count_rst", spawn_count, 0);
            chk("busy_wave", busy, 1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_enable"}, enable, 0);
        chk({tag, "_summon"}, Summon, 0);
        chk({tag, "_wave"}, wave_index, 0);
        chk({tag, "_count"}, spawn_count, 0);
        chk({tag, "_lives"}, lives, 2);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_clear"}, level_clear, 0);
        chk({tag, "_over"}, game_over, 0);
    endtask

    initial begin
        spawn_t s;
        Reset_n = 1'b0; frame_clk = 1'b0; start = 1'b0; level_index = 3'd0;
        used_array = 8'h00; achieve_array = 8'h00;
        repeat (3) step();
        chk_reset_outputs("reset");
        Reset_n = 1'b1;
        step();

        // First spawns of level 0: timing and slot order.
        level_index = 3'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        frames = 0;
        q.delete();
        chk("start_busy", busy, 1);
        wait_spawn(6, s);
        chk("first_en", s.en, 8'h01);
        chk("first_frame", s.fr, 3);
        chk("first_summon", s.sm, 0);
        chk("en_one_cycle", q.size(), 0);
        used_array[0] = 1'b1;
        wait_spawn(6, s);
        chk("second_en", s.en, 8'h02);
        chk("second_frame", s.fr, 5);
        used_array[1] = 1'b1;

        // All slots busy: spawning stalls until slot 5 frees.
        used_array = 8'hFF;
        repeat (4) frame();
        chk("stall_no_en", q.size(), 0);
        chk("stall_count", spawn_count, 2);
        used_array[5] = 1'b0;
        step();
        step();
        chk("release_q", q.size(), 1);
        if (q.size() != 0) s = q.pop_front();
        else s.en = 8'h00;
        chk("release_en", s.en, 8'h20);
        chk("release_summon", s.sm, 0);
        used_array[5] = 1'b1;
        run_spawns(0, 4, 3);
        clear_wave(0, 4);

        // Reset in the middle of wave 1's pause.
        frame();
        chk("pre_rst_wave", wave_index, 1);
        chk("pre_rst_busy", busy, 1);
        Reset_n = 1'b0;
        step();
        chk_reset_outputs("midrst");
        Reset_n = 1'b1;
        used_array = 8'h00;
        q.delete();
        step();

        // Level selector above 2 clamps to 8 monsters per wave.
        level_index = 3'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_wave", wave_index, 0);
        chk("restart_count", spawn_count, 0);
        for (int w = 0; w < 3; w++) begin
            run_spawns(w, 8, 0);
            clear_wave(w, 8);
        end

        // Restart from DONE, then two leaks in one cycle.
        level_index = 3'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_clear", level_clear, 0);
        chk("restart_lives", lives, 2);
        step();
        used_array = 8'b0001_0010;
        achieve_array = 8'b0001_0010;
        step();
        chk("dbl_leak_lives", lives, 0);
        chk("dbl_leak_not_yet", game_over, 0);
        step();
        chk("dbl_leak_over", game_over, 1);
        chk("dbl_leak_busy", busy, 0);
        repeat (3) step();
        chk("lost_hold_lives", lives, 0);
        used_array = 8'h00;
        achieve_array = 8'h00;

        // Restart from LOST; a held leak costs exactly one life.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("relost_over", game_over, 0);
        chk("relost_lives", lives, 2);
        used_array[3] = 1'b1;
        achieve_array[3] = 1'b1;
        step();
        chk("leak_once", lives, 1);
        repeat (5) frame();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) frame();
        chk("leak_held", lives, 1);
        chk("leak_no_over", game_over, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
